uart_periph: RTL

UART_PERIPH -- requirements
Module: uart_periph

---
 rtl/cpu_defs.sv | 21 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_periph.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the UART peripheral: oversampling ratio and the
// state encodings of the receive and transmit machines.
package cpu_defs;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks; clr
// restarts the count so the receiver can align ticks to a start edge.
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk_50m,
    input  logic reset_b,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_50m) begin
        if (!reset_b || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_periph.sv
// 8N1 UART: 16x oversampled receiver with overrun/frame-error reporting and
// an independent transmitter timed by its own bit-period counter.
module uart_periph
    import cpu_defs::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk_50m,
    input  logic       reset_b,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int DIV     = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int BIT_CYC = DIV * OVERSAMPLE;
    localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [3:0]    HALF_LAST = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    FULL_LAST = 4'(OVERSAMPLE - 1);

    // ---------------- receive path ----------------
    logic rxd_meta, rxd_sync, rxd_prev;

    always_ff @(posedge clk_50m) begin
        if (!reset_b) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    rx_state_t  rx_state, rx_state_nxt;
    logic [3:0] rx_tcnt, rx_tcnt_nxt;
    logic [2:0] rx_bit, rx_bit_nxt;
    logic [7:0] rx_shift, rx_shift_nxt;
    logic       rx_clr, rx_tick, byte_done, frame_bad;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk_50m (clk_50m),
        .reset_b (reset_b),
        .clr     (rx_clr),
        .tick    (rx_tick)
    );

    always_ff @(posedge clk_50m) begin
        if (!reset_b) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_tcnt  <= rx_tcnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_tcnt_nxt  = rx_tcnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_clr       = 1'b0;
        byte_done    = 1'b0;
        frame_bad    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rxd_prev && !rxd_sync) begin
                    rx_state_nxt = RX_START;
                    rx_tcnt_nxt  = '0;
                    rx_clr       = 1'b1;
                end
            end
            RX_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (rx_tick) begin
                    if (rx_tcnt == HALF_LAST) begin
                        rx_tcnt_nxt  = '0;
                        rx_bit_nxt   = '0;
                        rx_state_nxt = rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tcnt_nxt = rx_tcnt + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    if (rx_tcnt == FULL_LAST) begin
                        rx_tcnt_nxt  = '0;
                        rx_shift_nxt = {rxd_sync, rx_shift[7:1]};
                        rx_bit_nxt   = rx_bit + 1'b1;
                        if (rx_bit == 3'd7) begin
                            rx_state_nxt = RX_STOP;
                        end
                    end else begin
                        rx_tcnt_nxt = rx_tcnt + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_tcnt == FULL_LAST) begin
                        rx_tcnt_nxt  = '0;
                        rx_state_nxt = RX_IDLE;
                        byte_done    = rxd_sync;
                        frame_bad    = !rxd_sync;
                    end else begin
                        rx_tcnt_nxt = rx_tcnt + 1'b1;
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // A byte landing in the same cycle as an ack replaces the acked byte
    // cleanly, so it is not an overrun.
    always_ff @(posedge clk_50m) begin
        if (!reset_b) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= frame_bad;
            if (byte_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            if (byte_done && rx_valid && !rx_ack) begin
                rx_overrun <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    // ---------------- transmit path ----------------
    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          bit_end;

    always_ff @(posedge clk_50m) begin
        if (!reset_b) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 1'b1;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        bit_end      = (tx_cnt == BIT_LAST);
        tx_ready     = 1'b0;
        uart_txd     = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_ready   = 1'b1;
                tx_cnt_nxt = '0;
                if (tx_valid) begin
                    tx_state_nxt = TX_START;
                    tx_shift_nxt = tx_data;
                    tx_bit_nxt   = '0;
                end
            end
            TX_START: begin
                uart_txd = 1'b0;
                if (bit_end) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                uart_txd = tx_shift[0];
                if (bit_end) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    tx_bit_nxt   = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

endmodule
